// File: rtl/alarm_input_pkg.sv
// Shared channel indices, key FSM state type and default 50 MHz timing
// for the alarm CPU input conditioner.
package alarm_input_pkg;

    localparam int CH_HOURS    = 0;
    localparam int CH_MINUTES  = 1;
    localparam int CH_OFF      = 2;
    localparam int CH_SETALARM = 3;
    localparam int CH_SETCLOCK = 4;
    localparam int CH_SWRESET  = 5;

    localparam int NUM_KEYS = 3;
    localparam int NUM_CH   = 6;

    // Only hours and minutes auto-repeat; off fires once per press.
    localparam logic [NUM_KEYS-1:0] KEY_REPEAT_EN = 3'b011;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_PULSE_CYCLES    = 50000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;
    localparam int DEF_CNT_W           = 25;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_HELD,
        KEY_REPEAT
    } key_state_e;

endpackage

// File: rtl/alarm_input_conditioner_debounce.sv
// Two-flop synchroniser followed by a restart-on-bounce debounce counter.
module debounce_sync
    import alarm_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/alarm_input_conditioner.sv
// Conditions board keys and switches into the six 1-bit inputs polled
// by the alarm CPU: press pulses with auto-repeat, and interlocked levels.
module alarm_input_conditioner
    import alarm_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic key_hours_n,
    input  logic key_minutes_n,
    input  logic key_off_n,
    input  logic sw_set_alarm,
    input  logic sw_set_clock,
    input  logic sw_reset,
    output logic hours_export,
    output logic minutes_export,
    output logic off_export,
    output logic set_alarm_export,
    output logic set_clock_export,
    output logic switch_reset_export
);

    logic [NUM_CH-1:0]   raw;
    logic [NUM_CH-1:0]   stable;
    logic [NUM_KEYS-1:0] key_pulse;
    logic                set_alarm_q;
    logic                set_clock_q;
    logic                sw_reset_q;

    assign raw[CH_HOURS]    = ~key_hours_n;
    assign raw[CH_MINUTES]  = ~key_minutes_n;
    assign raw[CH_OFF]      = ~key_off_n;
    assign raw[CH_SETALARM] = sw_set_alarm;
    assign raw[CH_SETCLOCK] = sw_set_clock;
    assign raw[CH_SWRESET]  = sw_reset;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_db
        debounce_sync #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_i   (clk_clk),
            .rst_i   (reset_reset),
            .raw_i   (raw[c]),
            .stable_o(stable[c])
        );
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_state_e       state_q;
        key_state_e       state_d;
        logic [CNT_W-1:0] dcnt_q;
        logic [CNT_W-1:0] dcnt_d;
        logic [CNT_W-1:0] pcnt_q;
        logic [CNT_W-1:0] pcnt_d;
        logic             pulse_q;
        logic             fire;

        // Delay counter is loaded with N-1 so a fire lands every N cycles.
        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            fire    = 1'b0;
            unique case (state_q)
                KEY_IDLE: begin
                    if (stable[k]) begin
                        state_d = KEY_HELD;
                        fire    = 1'b1;
                        dcnt_d  = CNT_W'(REPEAT_DELAY - 1);
                    end
                end
                KEY_HELD: begin
                    if (!stable[k]) begin
                        state_d = KEY_IDLE;
                    end else if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - CNT_W'(1);
                    end else if (KEY_REPEAT_EN[k]) begin
                        state_d = KEY_REPEAT;
                        fire    = 1'b1;
                        dcnt_d  = CNT_W'(REPEAT_PERIOD - 1);
                    end
                end
                KEY_REPEAT: begin
                    if (!stable[k]) begin
                        state_d = KEY_IDLE;
                    end else if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - CNT_W'(1);
                    end else begin
                        fire   = 1'b1;
                        dcnt_d = CNT_W'(REPEAT_PERIOD - 1);
                    end
                end
                default: state_d = KEY_IDLE;
            endcase
        end

        // Pulse counter runs independently of the FSM so release never truncates.
        always_comb begin
            pcnt_d = '0;
            if (fire) begin
                pcnt_d = CNT_W'(PULSE_CYCLES);
            end else if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                state_q <= KEY_IDLE;
                dcnt_q  <= '0;
                pcnt_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                pcnt_q  <= pcnt_d;
                pulse_q <= (pcnt_d != '0);
            end
        end

        assign key_pulse[k] = pulse_q;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            set_alarm_q <= 1'b0;
            set_clock_q <= 1'b0;
            sw_reset_q  <= 1'b0;
        end else begin
            set_alarm_q <= stable[CH_SETALARM] & ~stable[CH_SETCLOCK];
            set_clock_q <= stable[CH_SETCLOCK];
            sw_reset_q  <= stable[CH_SWRESET];
        end
    end

    assign hours_export        = key_pulse[CH_HOURS];
    assign minutes_export      = key_pulse[CH_MINUTES];
    assign off_export          = key_pulse[CH_OFF];
    assign set_alarm_export    = set_alarm_q;
    assign set_clock_export    = set_clock_q;
    assign switch_reset_export = sw_reset_q;

endmodule

// File: tb/tb_alarm_input_conditioner.sv
// Scoreboard bench: expected pulse start cycles are queued at stimulus time
// and matched by a monitor; switch levels are checked inline per task.
module tb_alarm_input_conditioner;

    localparam int DB = 8;
    localparam int PW = 4;
    localparam int RD = 40;
    localparam int RP = 16;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic rst;
    logic key_hours_n, key_minutes_n, key_off_n;
    logic sw_set_alarm, sw_set_clock, sw_reset;
    logic hours_export, minutes_export, off_export;
    logic set_alarm_export, set_clock_export, switch_reset_export;

    alarm_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PW),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk_clk            (clk),
        .reset_reset        (rst),
        .key_hours_n        (key_hours_n),
        .key_minutes_n      (key_minutes_n),
        .key_off_n          (key_off_n),
        .sw_set_alarm       (sw_set_alarm),
        .sw_set_clock       (sw_set_clock),
        .sw_reset           (sw_reset),
        .hours_export       (hours_export),
        .minutes_export     (minutes_export),
        .off_export         (off_export),
        .set_alarm_export   (set_alarm_export),
        .set_clock_export   (set_clock_export),
        .switch_reset_export(switch_reset_export)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int ch;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    logic [2:0] prev_k = 3'b000;
    int         width [3];

    function automatic logic [5:0] outs_now();
        return {switch_reset_export, set_clock_export, set_alarm_export,
                off_export, minutes_export, hours_export};
    endfunction

    // Pulse monitor: each rising edge pops one expected entry; each falling
    // edge checks the high time. Reset discards any pulse in flight.
    always @(negedge clk) begin
        logic [2:0] now_k;
        now_k = {off_export, minutes_export, hours_export};
        if (rst) begin
            prev_k = 3'b000;
            for (int i = 0; i < 3; i++) width[i] = 0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                if (now_k[ch] && !prev_k[ch]) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL pulse_unexpected: ch=%0d rose at cycle %0d, expected no pulse", ch, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.ch !== ch || e.at !== cyc) begin
                            fails++;
                            $display("FAIL pulse_start: got ch=%0d cycle=%0d, expected ch=%0d cycle=%0d",
                                     ch, cyc, e.ch, e.at);
                        end
                    end
                    width[ch] = 1;
                end else if (now_k[ch]) begin
                    width[ch]++;
                end else if (prev_k[ch]) begin
                    tests++;
                    if (width[ch] !== PW) begin
                        fails++;
                        $display("FAIL pulse_width: ch=%0d width=%0d, expected %0d", ch, width[ch], PW);
                    end
                end
            end
            prev_k = now_k;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int at);
        exp_t x;
        x.ch = ch;
        x.at = at;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if (outs_now() !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected 000000", outs_now());
        end
        rst = 1'b0;
        tick();
        tests++;
        if (outs_now() !== 6'b0) begin
            fails++;
            $display("FAIL reset_first_cycle: got %b, expected 000000", outs_now());
        end
        repeat (5) tick();
    endtask

    task automatic test_hours_single();
        int t0;
        t0 = cyc;
        key_hours_n = 1'b0;
        push(0, t0 + LAT);
        repeat (20) tick();
        key_hours_n = 1'b1;
        repeat (30) tick();
        tests++;
        if (exp_q.size() !== 0 || outs_now() !== 6'b0) begin
            fails++;
            $display("FAIL hours_single: pending=%0d outs=%b, expected 0 pending, 000000",
                     exp_q.size(), outs_now());
            exp_q.delete();
        end
    endtask

    task automatic test_minutes_repeat();
        int t0;
        t0 = cyc;
        key_minutes_n = 1'b0;
        push(1, t0 + LAT);
        for (int n = 0; n < 4; n++) push(1, t0 + LAT + RD + n * RP);
        repeat (100) tick();
        key_minutes_n = 1'b1;
        repeat (40) tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL minutes_repeat: %0d pulses missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_off_no_repeat();
        int t0;
        t0 = cyc;
        key_off_n = 1'b0;
        push(2, t0 + LAT);
        repeat (100) tick();
        key_off_n = 1'b1;
        repeat (30) tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL off_single: %0d pulses missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        int ts;
        for (int i = 0; i < 12; i++) begin
            key_hours_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (5) tick();
        end
        ts = cyc;
        key_hours_n = 1'b0;
        push(0, ts + LAT);
        repeat (20) tick();
        key_hours_n = 1'b1;
        repeat (30) tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL bounce: %0d pulses missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_concurrent();
        int t0;
        t0 = cyc;
        key_hours_n   = 1'b0;
        key_minutes_n = 1'b0;
        push(0, t0 + LAT);
        push(1, t0 + LAT);
        repeat (20) tick();
        key_hours_n   = 1'b1;
        key_minutes_n = 1'b1;
        repeat (30) tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL concurrent: %0d pulses missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_switches();
        sw_set_clock = 1'b1;
        repeat (LAT - 1) tick();
        tests++;
        if (set_clock_export !== 1'b0) begin
            fails++;
            $display("FAIL set_clock_early: got %b, expected 0", set_clock_export);
        end
        tick();
        tests++;
        if (set_clock_export !== 1'b1) begin
            fails++;
            $display("FAIL set_clock_rise: got %b, expected 1", set_clock_export);
        end
        sw_set_alarm = 1'b1;
        repeat (15) tick();
        tests++;
        if ({set_clock_export, set_alarm_export} !== 2'b10) begin
            fails++;
            $display("FAIL interlock: clock,alarm=%b, expected 10",
                     {set_clock_export, set_alarm_export});
        end
        sw_set_clock = 1'b0;
        repeat (LAT - 1) tick();
        tests++;
        if (set_alarm_export !== 1'b0) begin
            fails++;
            $display("FAIL set_alarm_early: got %b, expected 0", set_alarm_export);
        end
        tick();
        tests++;
        if ({set_clock_export, set_alarm_export} !== 2'b01) begin
            fails++;
            $display("FAIL set_alarm_rise: clock,alarm=%b, expected 01",
                     {set_clock_export, set_alarm_export});
        end
        sw_set_alarm = 1'b0;
        sw_reset     = 1'b1;
        repeat (LAT) tick();
        tests++;
        if (outs_now() !== 6'b100000) begin
            fails++;
            $display("FAIL switch_reset: outs=%b, expected 100000", outs_now());
        end
        sw_reset = 1'b0;
        repeat (15) tick();
        tests++;
        if (outs_now() !== 6'b0) begin
            fails++;
            $display("FAIL switches_clear: outs=%b, expected 000000", outs_now());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int t0;
        int tr;
        t0 = cyc;
        key_minutes_n = 1'b0;
        push(1, t0 + LAT);
        push(1, t0 + LAT + RD);
        push(1, t0 + LAT + RD + RP);
        repeat (LAT + RD + RP + 2) tick();
        tests++;
        if (minutes_export !== 1'b1) begin
            fails++;
            $display("FAIL mid_pulse: minutes=%b, expected 1", minutes_export);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (outs_now() !== 6'b0) begin
            fails++;
            $display("FAIL reset_immediate: outs=%b, expected 000000", outs_now());
        end
        repeat (3) tick();
        rst = 1'b0;
        tr  = cyc;
        push(1, tr + LAT);
        tick();
        tests++;
        if (outs_now() !== 6'b0) begin
            fails++;
            $display("FAIL reset_release: outs=%b, expected 000000", outs_now());
        end
        repeat (20) tick();
        key_minutes_n = 1'b1;
        repeat (30) tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL reset_repress: %0d pulses missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst           = 1'b1;
        key_hours_n   = 1'b1;
        key_minutes_n = 1'b1;
        key_off_n     = 1'b1;
        sw_set_alarm  = 1'b0;
        sw_set_clock  = 1'b0;
        sw_reset      = 1'b0;
        test_reset();
        test_hours_single();
        test_minutes_repeat();
        test_off_no_repeat();
        test_bounce();
        test_concurrent();
        test_switches();
        test_reset_mid_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_input_conditioner.md
Name: alarm_input_conditioner

Overview:
Front-end for the alarm CPU's input ports. It produces the six 1-bit inputs the CPU polls: hours, minutes, off, set_alarm, set_clock and switch_reset. Raw board keys (active-low) and slide switches are synchronised and debounced. Keys become fixed-width press pulses, with auto-repeat on hours/minutes. Switches become clean levels, with a set_clock/set_alarm interlock. Outputs connect 1:1 to the CPU's same-named inputs.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must hold a new value before it is accepted (20 ms @ 50 MHz)
PULSE_CYCLES, 50000, high time of each key pulse (1 ms); must be < DEBOUNCE_CYCLES and < REPEAT_PERIOD
REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat pulse (0.5 s)
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (0.2 s)
CNT_W, 25, counter width; must hold max(REPEAT_DELAY, DEBOUNCE_CYCLES)

Ports:
clk_clk  in  1  system clock, single clock domain
reset_reset  in  1  asynchronous, active-high reset
key_hours_n  in  1  raw hours key, active-low, asynchronous
key_minutes_n  in  1  raw minutes key, active-low, asynchronous
key_off_n  in  1  raw alarm-off key, active-low, asynchronous
sw_set_alarm  in  1  raw switch, active-high, asynchronous
sw_set_clock  in  1  raw switch, active-high, asynchronous
sw_reset  in  1  raw switch, active-high, asynchronous
hours_export  out  1  press pulse, with auto-repeat
minutes_export  out  1  press pulse, with auto-repeat
off_export  out  1  press pulse, no repeat
set_alarm_export  out  1  debounced level, interlocked
set_clock_export  out  1  debounced level
switch_reset_export  out  1  debounced level

Behaviour:
- Reset is asynchronous and active-high.
  - Sync flops, stable values, counters and FSMs all clear to "released/0".
  - All outputs are 0 during reset and on the first cycle after release.
  - All outputs are registered.
- Keys are inverted at entry; internally 1 means pressed.
- Per input (debounce_sync):
  - 2-FF synchroniser, then debounce counter cnt.
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Else: cnt++.
  - A clean raw edge changes stable DEBOUNCE_CYCLES+2 cycles after the first sampling edge.
  - Any bounce inside the window restarts the count.
- Key channel FSM (hours, minutes, off), states IDLE, HELD, REPEAT:
  - IDLE -> HELD on stable 0->1. A pulse fires and the delay counter loads REPEAT_DELAY.
  - HELD: the counter decrements. At 0, a pulse fires, the counter loads REPEAT_PERIOD, and the FSM goes to REPEAT (hours/minutes only; off stays in HELD and never repeats).
  - REPEAT: at counter 0, a pulse fires and the counter reloads REPEAT_PERIOD.
  - HELD or REPEAT -> IDLE on stable 1->0.
- Pulse timing:
  - "Pulse fires" loads the pulse counter with PULSE_CYCLES.
  - The output goes high the cycle after the firing edge and stays high exactly PULSE_CYCLES cycles.
  - Release never truncates an in-flight pulse.
  - A new fire while a pulse is in flight reloads the counter (one merged pulse). This is unreachable when the parameter constraints hold.
- Channels are fully independent; simultaneous hours+minutes presses give concurrent pulses.
- Switch channels:
  - set_clock_export = stable(set_clock).
  - switch_reset_export = stable(sw_reset).
  - set_alarm_export = stable(set_alarm) AND NOT stable(set_clock); set_clock has priority.
  - Each output is registered, so it appears one cycle after stable changes.
- A key held through reset release is seen as a new press: pulse at DEBOUNCE_CYCLES+3 cycles after release.
- A switch held high through reset release appears at DEBOUNCE_CYCLES+3 cycles after release.
- Reset asserted mid-pulse or mid-repeat clears immediately; no residual pulse after release unless the key is still held (previous rule applies).

Decomposition:
- Package alarm_input_pkg:
  - Channel index constants CH_HOURS..CH_SWRESET.
  - Typedef for key FSM state (IDLE/HELD/REPEAT).
  - Default timing constants at 50 MHz.
- Sub-module debounce_sync (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES), instantiated six times.
- Key FSM and pulse generation stay in the top module, with a per-channel repeat-enable constant.

Test Plan:
Test parameters: DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, REPEAT_DELAY=40, REPEAT_PERIOD=16.
1. key_hours_n low at cycle 100, held 20 cycles -> hours_export high cycles 111..114 only; no other output toggles.
2. key_minutes_n held 100 cycles -> minutes_export pulses start at 111, 151, 167, 183, 199; none after release debounce.
3. key_off_n held 100 cycles -> exactly one off_export pulse; no repeat.
4. key_hours_n toggling every 5 cycles for 60 cycles, then steady low -> zero pulses during bouncing; one pulse starting 11 cycles after the steady low begins.
5. sw_set_clock=1, then sw_set_alarm=1 -> set_clock_export=1, set_alarm_export=0. Drop sw_set_clock -> set_alarm_export rises 11 cycles later.
6. Assert reset_reset mid-repeat (minutes held) for 3 cycles -> all outputs 0 immediately. Key still held -> next pulse starts 11 cycles after reset release.
